// File: rtl/alu_arbiter.sv
// Two-port sequencer for the shared EX-stage ALU: accepts one request at a time,
// drives the external ALU for one cycle, and returns the captured result to the granted port.
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid0,
    output logic        req_ready0,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [2:0]  req_op0,
    input  logic [4:0]  req_shift0,

    input  logic        req_valid1,
    output logic        req_ready1,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [2:0]  req_op1,
    input  logic [4:0]  req_shift1,

    output logic        resp_valid0,
    input  logic        resp_ready0,
    output logic        resp_valid1,
    input  logic        resp_ready1,
    output logic [31:0] resp_data,
    output logic        resp_zero,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic [4:0]  alu_shift,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,

    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  shift_q, shift_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_zero_q, resp_zero_d;
    logic [15:0] op_count_q, op_count_d;

    logic        win;
    logic        resp_ready_gnt;

    // A lone requester always wins; on a tie, round-robin favours the port not served last.
    always_comb begin
        win = req_valid1;
        if (req_valid0 && req_valid1) begin
            win = (RR_EN != 0) ? ~last_q : 1'b0;
        end
    end

    assign resp_ready_gnt = gnt_q ? resp_ready1 : resp_ready0;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        shift_d     = shift_q;
        resp_data_d = resp_data_q;
        resp_zero_d = resp_zero_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid0 || req_valid1) begin
                    gnt_d   = win;
                    last_d  = win;
                    a_d     = win ? req_a1     : req_a0;
                    b_d     = win ? req_b1     : req_b0;
                    op_d    = win ? req_op1    : req_op0;
                    shift_d = win ? req_shift1 : req_shift0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                resp_data_d = alu_out;
                resp_zero_d = alu_zero;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready_gnt) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            shift_q     <= '0;
            resp_data_q <= '0;
            resp_zero_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            shift_q     <= shift_d;
            resp_data_q <= resp_data_d;
            resp_zero_q <= resp_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    // Handshake and status outputs depend on registered state only.
    assign req_ready0  = (state_q == IDLE);
    assign req_ready1  = (state_q == IDLE);
    assign resp_valid0 = (state_q == RESP) && !gnt_q;
    assign resp_valid1 = (state_q == RESP) &&  gnt_q;
    assign busy        = (state_q != IDLE);
    assign resp_data   = resp_data_q;
    assign resp_zero   = resp_zero_q;
    assign op_count    = op_count_q;

    assign alu_a     = (state_q == ISSUE) ? a_q     : '0;
    assign alu_b     = (state_q == ISSUE) ? b_q     : '0;
    assign alu_op    = (state_q == ISSUE) ? op_q    : '0;
    assign alu_shift = (state_q == ISSUE) ? shift_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU, accept-time scoreboard, vector table and corner sequences.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic        req_ready0, req_ready1;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [2:0]  req_op0 = '0, req_op1 = '0;
    logic [4:0]  req_shift0 = '0, req_shift1 = '0;
    logic        resp_valid0, resp_valid1;
    logic        resp_ready0 = 1'b0, resp_ready1 = 1'b0;
    logic [31:0] resp_data;
    logic        resp_zero;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic [4:0]  alu_shift;
    logic        alu_zero;
    logic        busy;
    logic [15:0] op_count;

    logic        f_req_valid0 = 1'b0, f_req_valid1 = 1'b0;
    logic        f_req_ready0, f_req_ready1;
    logic [31:0] f_req_a0 = '0, f_req_b0 = '0, f_req_a1 = '0, f_req_b1 = '0;
    logic [2:0]  f_req_op0 = '0, f_req_op1 = '0;
    logic [4:0]  f_req_shift0 = '0, f_req_shift1 = '0;
    logic        f_resp_valid0, f_resp_valid1;
    logic        f_resp_ready0 = 1'b0, f_resp_ready1 = 1'b0;
    logic [31:0] f_resp_data;
    logic        f_resp_zero;
    logic [31:0] f_alu_a, f_alu_b, f_alu_out;
    logic [2:0]  f_alu_op;
    logic [4:0]  f_alu_shift;
    logic        f_alu_zero;
    logic        f_busy;
    logic [15:0] f_op_count;

    int total = 0;
    int bad = 0;

    // Reference ALU: {zero, result}
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a | b;
            3'b011:  r = a & b;
            3'b100:  r = {31'b0, ($signed(a) < $signed(b))};
            3'b101:  r = b << a[4:0];
            3'b110:  r = b << sh;
            default: r = $signed(b) >>> a[4:0];
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_zero, alu_out}     = alu_f(alu_a, alu_b, alu_op, alu_shift);
    assign {f_alu_zero, f_alu_out} = alu_f(f_alu_a, f_alu_b, f_alu_op, f_alu_shift);

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid0(req_valid0), .req_ready0(req_ready0), .req_a0(req_a0), .req_b0(req_b0),
        .req_op0(req_op0), .req_shift0(req_shift0),
        .req_valid1(req_valid1), .req_ready1(req_ready1), .req_a1(req_a1), .req_b1(req_b1),
        .req_op1(req_op1), .req_shift1(req_shift1),
        .resp_valid0(resp_valid0), .resp_ready0(resp_ready0),
        .resp_valid1(resp_valid1), .resp_ready1(resp_ready1),
        .resp_data(resp_data), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shift(alu_shift),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .req_valid0(f_req_valid0), .req_ready0(f_req_ready0), .req_a0(f_req_a0), .req_b0(f_req_b0),
        .req_op0(f_req_op0), .req_shift0(f_req_shift0),
        .req_valid1(f_req_valid1), .req_ready1(f_req_ready1), .req_a1(f_req_a1), .req_b1(f_req_b1),
        .req_op1(f_req_op1), .req_shift1(f_req_shift1),
        .resp_valid0(f_resp_valid0), .resp_ready0(f_resp_ready0),
        .resp_valid1(f_resp_valid1), .resp_ready1(f_resp_ready1),
        .resp_data(f_resp_data), .resp_zero(f_resp_zero),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_shift(f_alu_shift),
        .alu_out(f_alu_out), .alu_zero(f_alu_zero),
        .busy(f_busy), .op_count(f_op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event required event within bound", name);
    endtask

    // Scoreboard: entries pushed at accept, popped at the response handshake.
    typedef struct {
        logic        p;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  sh;
        logic [31:0] d;
        logic        z;
    } exp_t;

    exp_t sb[$];
    logic m_last = 1'b1;

    always @(negedge clk) begin : mon
        exp_t e;
        logic [32:0] r;
        logic w;
        if (!reset) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            chk("resp_onehot", 32'(resp_valid0 & resp_valid1), 32'd0);
            if (resp_valid0 || resp_valid1) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 32'(resp_valid0 | resp_valid1), 32'd0);
                end else if ((resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1)) begin
                    e = sb.pop_front();
                    chk("sb_port", 32'(resp_valid1), 32'(e.p));
                    chk("sb_data", resp_data, e.d);
                    chk("sb_zero", 32'(resp_zero), 32'(e.z));
                end
            end
            if (busy && !resp_valid0 && !resp_valid1 && sb.size() > 0) begin
                chk("issue_a", alu_a, sb[$].a);
                chk("issue_b", alu_b, sb[$].b);
                chk("issue_op_sh", 32'({alu_op, alu_shift}), 32'({sb[$].op, sb[$].sh}));
            end else if (!busy || resp_valid0 || resp_valid1) begin
                chk("alu_idle", alu_a | alu_b | 32'({alu_op, alu_shift}), 32'd0);
            end
            if (req_ready0 && (req_valid0 || req_valid1)) begin
                w = (req_valid0 && req_valid1) ? ~m_last : req_valid1;
                e.p  = w;
                e.a  = w ? req_a1 : req_a0;
                e.b  = w ? req_b1 : req_b0;
                e.op = w ? req_op1 : req_op0;
                e.sh = w ? req_shift1 : req_shift0;
                r = alu_f(e.a, e.b, e.op, e.sh);
                e.d = r[31:0];
                e.z = r[32];
                sb.push_back(e);
                m_last = w;
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic do_op(input logic p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [4:0] sh,
                         output logic [31:0] d, output logic z);
        bit got;
        d = '0;
        z = 1'b0;
        @(posedge clk); #1;
        if (p) begin
            req_a1 = a; req_b1 = b; req_op1 = op; req_shift1 = sh;
            req_valid1 = 1'b1; resp_ready1 = 1'b1;
        end else begin
            req_a0 = a; req_b0 = b; req_op0 = op; req_shift0 = sh;
            req_valid0 = 1'b1; resp_ready0 = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p ? req_ready1 : req_ready0;
        end
        if (!got) timeout("accept_wait");
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p ? resp_valid1 : resp_valid0;
            if (got) begin
                d = resp_data;
                z = resp_zero;
            end
        end
        if (!got) timeout("resp_wait");
        @(posedge clk); #1;
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
    endtask

    typedef struct {
        logic        p;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  sh;
        logic [31:0] d;
        logic        z;
    } vec_t;

    initial begin : main
        vec_t        vt[11];
        logic [31:0] d;
        logic        z;
        logic [15:0] cnt;
        int          order[$];
        int          acc;
        int          g0;
        int          g1;
        bit          got;

        vt[0]  = '{1'b0, 32'd5,        32'd7,        3'b000, 5'd0,  32'd12,       1'b0};
        vt[1]  = '{1'b1, 32'd5,        32'd5,        3'b001, 5'd0,  32'd0,        1'b1};
        vt[2]  = '{1'b0, 32'hF0F00000, 32'h00000F0F, 3'b010, 5'd0,  32'hF0F00F0F, 1'b0};
        vt[3]  = '{1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 3'b011, 5'd0,  32'h0F000F00, 1'b0};
        vt[4]  = '{1'b0, 32'hFFFFFFFF, 32'd2,        3'b100, 5'd0,  32'd1,        1'b0};
        vt[5]  = '{1'b1, 32'd2,        32'hFFFFFFFF, 3'b100, 5'd0,  32'd0,        1'b1};
        vt[6]  = '{1'b0, 32'd4,        32'd3,        3'b101, 5'd9,  32'h00000030, 1'b0};
        vt[7]  = '{1'b1, 32'd0,        32'd1,        3'b110, 5'd31, 32'h80000000, 1'b0};
        vt[8]  = '{1'b0, 32'd4,        32'h80000000, 3'b111, 5'd0,  32'hF8000000, 1'b0};
        vt[9]  = '{1'b1, 32'd0,        32'd0,        3'b000, 5'd0,  32'd0,        1'b1};
        vt[10] = '{1'b0, 32'd0,        32'd1,        3'b001, 5'd0,  32'hFFFFFFFF, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready0", 32'(req_ready0), 32'd1);
        chk("rst_req_ready1", 32'(req_ready1), 32'd1);
        chk("rst_resp_valid", 32'({resp_valid0, resp_valid1}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_resp", 32'({resp_zero, resp_data[30:0]}) | resp_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset while in ISSUE discards the operation
        req_a0 = 32'd11; req_b0 = 32'd22; req_op0 = 3'b000; req_shift0 = 5'd0;
        req_valid0 = 1'b1; resp_ready0 = 1'b1;
        @(negedge clk);
        chk("midrst_accept_ready", 32'(req_ready0), 32'd1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_issue_busy", 32'(busy), 32'd1);
        chk("midrst_issue_a", alu_a, 32'd11);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid0), 32'd0);
            chk("midrst_idle", 32'(busy), 32'd0);
            chk("midrst_op_count", 32'(op_count), 32'd0);
        end
        resp_ready0 = 1'b0;

        // Vector table, one operation per entry
        for (int i = 0; i < 11; i++) begin
            cnt = op_count;
            do_op(vt[i].p, vt[i].a, vt[i].b, vt[i].op, vt[i].sh, d, z);
            chk($sformatf("vec%0d_data", i), d, vt[i].d);
            chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vt[i].z));
            @(negedge clk);
            chk($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(cnt + 16'd1));
        end

        // Round-robin tie from reset: 0,1,0,1
        pulse_reset();
        req_a0 = 32'd9; req_b0 = 32'd9; req_op0 = 3'b001; req_shift0 = 5'd0;
        req_a1 = 32'hFFFFFFFF; req_b1 = 32'd2; req_op1 = 3'b100; req_shift1 = 5'd0;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        resp_ready0 = 1'b1; resp_ready1 = 1'b1;
        acc = 0;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            @(negedge clk);
            if (resp_valid0) begin
                order.push_back(0);
                chk("tie_p0_data", resp_data, 32'd0);
                chk("tie_p0_zero", 32'(resp_zero), 32'd1);
            end
            if (resp_valid1) begin
                order.push_back(1);
                chk("tie_p1_data", resp_data, 32'd1);
                chk("tie_p1_zero", 32'(resp_zero), 32'd0);
            end
            if (req_ready0 && (req_valid0 || req_valid1)) acc++;
            @(posedge clk); #1;
            if (acc >= 4) begin
                req_valid0 = 1'b0;
                req_valid1 = 1'b0;
            end
        end
        if (order.size() < 4) timeout("tie_responses");
        for (int i = 0; i < order.size(); i++) begin
            chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(i % 2));
        end
        resp_ready0 = 1'b0; resp_ready1 = 1'b0;

        // Fixed priority: port 0 always wins while it stays valid
        f_req_a0 = 32'd3; f_req_b0 = 32'd4; f_req_op0 = 3'b000;
        f_req_a1 = 32'd8; f_req_b1 = 32'd1; f_req_op1 = 3'b001;
        f_req_valid0 = 1'b1; f_req_valid1 = 1'b1;
        f_resp_ready0 = 1'b1; f_resp_ready1 = 1'b1;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 60 && g0 < 4; i++) begin
            @(negedge clk);
            chk("fp_ready1_idle_only", 32'(f_req_ready1), 32'(!f_busy));
            if (f_resp_valid1) g1++;
            if (f_resp_valid0) begin
                g0++;
                chk("fp_data", f_resp_data, 32'd7);
                chk("fp_zero", 32'(f_resp_zero), 32'd0);
            end
            @(posedge clk); #1;
            if (g0 >= 4) begin
                f_req_valid0 = 1'b0;
                f_req_valid1 = 1'b0;
            end
        end
        if (g0 < 4) timeout("fp_grants");
        @(negedge clk);
        chk("fp_port1_grants", 32'(g1), 32'd0);
        chk("fp_op_count", 32'(f_op_count), 32'd4);
        chk("fp_idle_after", 32'(f_busy), 32'd0);
        f_resp_ready0 = 1'b0; f_resp_ready1 = 1'b0;

        // Backpressure on port 1
        @(posedge clk); #1;
        req_a1 = 32'd0; req_b1 = 32'd1; req_op1 = 3'b110; req_shift1 = 5'd31;
        req_valid1 = 1'b1; resp_ready1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready1;
        end
        if (!got) timeout("bp_accept");
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp_valid1;
        end
        if (!got) timeout("bp_resp");
        cnt = op_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", resp_data, 32'h80000000);
            chk("bp_valid", 32'({resp_valid1, resp_valid0}), 32'd2);
            chk("bp_ready", 32'({req_ready0, req_ready1}), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_op_count", 32'(op_count), 32'(cnt));
        end
        @(posedge clk); #1;
        resp_ready1 = 1'b1;
        @(posedge clk); #1;
        resp_ready1 = 1'b0;
        @(negedge clk);
        chk("bp_done_busy", 32'(busy), 32'd0);
        chk("bp_done_op_count", 32'(op_count), 32'(cnt + 16'd1));

        // Counter wrap
        @(posedge clk); #1;
        force dut.op_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.op_count_q;
        chk("wrap_preset", 32'(op_count), 32'h0000FFFE);
        do_op(1'b0, 32'd1, 32'd1, 3'b000, 5'd0, d, z);
        @(negedge clk);
        chk("wrap_ffff", 32'(op_count), 32'h0000FFFF);
        do_op(1'b1, 32'd1, 32'd1, 3'b011, 5'd0, d, z);
        @(negedge clk);
        chk("wrap_zero", 32'(op_count), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish required finish by 200000");
        $fatal(1);
    end

endmodule
